load_store_unit: RTL and testbench

Memory-stage load/store unit for the pipelined RISC-V core. It sits directly downstream of decode/execute and consumes the effective address, the store data and the `truncSrc` control from execute. It runs a request/acknowledge transaction on the data-memory bus, generates byte enables and lane-aligned store data, and sign- or zero-extends load results. The pipeline is stalled while a transaction is outstanding.

---
 rtl/load_store_unit_if.sv | 54 +++++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Load/store unit channels: execute-side request/response and the
// request/acknowledge data-memory bus.
interface load_store_unit_req_if #(
`ifdef BIT_COUNT_64
    parameter int XLEN = 64
`else
    parameter int XLEN = 32
`endif
);
    logic            req_valid;
    logic            req_ready;
    logic            is_store;
    logic [2:0]      trunc;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] store_data;
    logic            stall;
    logic            resp_valid;
    logic [XLEN-1:0] load_data;
    logic            misaligned;

    modport master (
        output req_valid, is_store, trunc, addr, store_data,
        input  req_ready, stall, resp_valid, load_data, misaligned
    );
    modport slave (
        input  req_valid, is_store, trunc, addr, store_data,
        output req_ready, stall, resp_valid, load_data, misaligned
    );
endinterface

interface load_store_unit_mem_if #(
`ifdef BIT_COUNT_64
    parameter int XLEN = 64
`else
    parameter int XLEN = 32
`endif
);
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_be;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one bus transaction per request,
// lane alignment of store data and sign/zero extension of loads.
module load_store_unit #(
`ifdef BIT_COUNT_64
    parameter int XLEN = 64
`else
    parameter int XLEN = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    load_store_unit_req_if.slave  req,
    load_store_unit_mem_if.master mem
);
    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
    localparam logic [1:0] FULL_SZ = 2'(OW);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e          state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      trunc_q, trunc_d;
    logic [OW-1:0]   off_q, off_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic            resp_valid_q, resp_valid_d;
    logic            misaligned_q, misaligned_d;
    logic [XLEN-1:0] load_data_q, load_data_d;

    logic [1:0]      req_sz;
    logic [OW-1:0]   req_off;
    logic            req_mis;
    logic [BW-1:0]   req_mask;

    // log2 of the access size in bytes; unsigned variants share their size
    function automatic logic [1:0] size_log2(input logic [2:0] t);
        case (t)
            3'd0, 3'd3: return 2'd0;
            3'd1, 3'd4: return 2'd1;
            3'd2:       return 2'd2;
            3'd5:       return (XLEN == 64) ? 2'd2 : FULL_SZ;
            default:    return FULL_SZ;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extend(
        input logic [XLEN-1:0] w,
        input logic [2:0]      t
    );
        logic [XLEN-1:0] r;
        r = w;
        case (t)
            3'd0: r = XLEN'($signed(w[7:0]));
            3'd1: r = XLEN'($signed(w[15:0]));
            3'd2: r = XLEN'($signed(w[31:0]));
            3'd3: r = XLEN'(w[7:0]);
            3'd4: r = XLEN'(w[15:0]);
            3'd5: r = (XLEN == 64) ? XLEN'(w[31:0]) : w;
            default: r = w;
        endcase
        return r;
    endfunction

    assign req_sz   = size_log2(req.trunc);
    assign req_off  = req.addr[OW-1:0];
    assign req_mis  = |(req_off & OW'((1 << req_sz) - 1));
    assign req_mask = BW'((1 << (1 << req_sz)) - 1);

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        trunc_d      = trunc_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        resp_valid_d = 1'b0;
        misaligned_d = 1'b0;
        load_data_d  = load_data_q;
        unique case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    is_store_d = req.is_store;
                    trunc_d    = req.trunc;
                    off_d      = req_off;
                    if (req_mis) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        misaligned_d = 1'b1;
                        load_data_d  = '0;
                    end else begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req.is_store;
                        mem_addr_d  = {req.addr[XLEN-1:OW], OW'(0)};
                        mem_wdata_d = req.store_data << {req_off, 3'b000};
                        mem_be_d    = req.is_store ? (req_mask << req_off) : '1;
                    end
                end
            end
            ACCESS: begin
                if (mem.mem_ack) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    if (!is_store_q)
                        load_data_d = extend(mem.mem_rdata >> {off_q, 3'b000}, trunc_q);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            trunc_q      <= '0;
            off_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            resp_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            trunc_q      <= trunc_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            resp_valid_q <= resp_valid_d;
            misaligned_q <= misaligned_d;
            load_data_q  <= load_data_d;
        end
    end

    // the pipeline is released in the response cycle
    assign req.req_ready  = (state_q == IDLE);
    assign req.stall      = (state_q == ACCESS) |
                            ((state_q == IDLE) & req.req_valid);
    assign req.resp_valid = resp_valid_q;
    assign req.misaligned = misaligned_q;
    assign req.load_data  = load_data_q;
    assign mem.mem_req    = mem_req_q;
    assign mem.mem_we     = mem_we_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;
    assign mem.mem_be     = mem_be_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit at XLEN=32 and XLEN=64, with a
// response scoreboard per instance.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_req_if #(.XLEN(32)) r32 ();
    load_store_unit_mem_if #(.XLEN(32)) m32 ();
    load_store_unit_req_if #(.XLEN(64)) r64 ();
    load_store_unit_mem_if #(.XLEN(64)) m64 ();

    load_store_unit #(.XLEN(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .req   (r32),
        .mem   (m32)
    );
    load_store_unit #(.XLEN(64)) dut64 (
        .clk   (clk),
        .reset (reset),
        .req   (r64),
        .mem   (m64)
    );

    typedef struct {
        string       tag;
        logic        mis;
        logic [63:0] ld;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            if (be[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    always @(negedge clk) begin
        if (r32.resp_valid === 1'b1) begin
            check("sb32_pending", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) begin
                e32 = q32.pop_front();
                check({e32.tag, "_mis"}, 64'(r32.misaligned), 64'(e32.mis));
                check({e32.tag, "_ld"}, 64'(r32.load_data), e32.ld);
                check({e32.tag, "_stall"}, 64'(r32.stall), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (r64.resp_valid === 1'b1) begin
            check("sb64_pending", 64'(q64.size() != 0), 64'd1);
            if (q64.size() != 0) begin
                e64 = q64.pop_front();
                check({e64.tag, "_mis"}, 64'(r64.misaligned), 64'(e64.mis));
                check({e64.tag, "_ld"}, r64.load_data, e64.ld);
            end
        end
    end

    task automatic reset_check32(input string p);
        check({p, "_ready"}, 64'(r32.req_ready), 64'd1);
        check({p, "_req"}, 64'(m32.mem_req), 64'd0);
        check({p, "_we"}, 64'(m32.mem_we), 64'd0);
        check({p, "_resp"}, 64'(r32.resp_valid), 64'd0);
        check({p, "_mis"}, 64'(r32.misaligned), 64'd0);
        check({p, "_ld"}, 64'(r32.load_data), 64'd0);
        check({p, "_addr"}, 64'(m32.mem_addr), 64'd0);
        check({p, "_wdata"}, 64'(m32.mem_wdata), 64'd0);
        check({p, "_be"}, 64'(m32.mem_be), 64'd0);
    endtask

    task automatic op32(input string tag, input logic st,
                        input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd,
                        input int waits, input logic [31:0] x_addr,
                        input logic [3:0] x_be, input logic [31:0] x_wd,
                        input logic [31:0] x_ld);
        logic [63:0] bm;
        bm = be_mask({4'h0, x_be});
        @(posedge clk); #1;
        r32.req_valid = 1'b1;
        r32.is_store = st;
        r32.trunc = t;
        r32.addr = a;
        r32.store_data = d;
        q32.push_back('{tag: tag, mis: 1'b0, ld: {32'h0, x_ld}});
        #1;
        check({tag, "_stall_req"}, 64'(r32.stall), 64'd1);
        check({tag, "_ready"}, 64'(r32.req_ready), 64'd1);
        @(posedge clk); #1;
        r32.req_valid = 1'b0;
        check({tag, "_mreq"}, 64'(m32.mem_req), 64'd1);
        check({tag, "_we"}, 64'(m32.mem_we), 64'(st));
        check({tag, "_addr"}, 64'(m32.mem_addr), 64'(x_addr));
        check({tag, "_be"}, 64'(m32.mem_be), 64'(x_be));
        if (st)
            check({tag, "_wdata"}, 64'(m32.mem_wdata) & bm, 64'(x_wd) & bm);
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"},
                  {m32.mem_req, m32.mem_be, m32.mem_addr, r32.stall, r32.resp_valid},
                  {1'b1, x_be, x_addr, 1'b1, 1'b0});
        end
        m32.mem_ack = 1'b1;
        m32.mem_rdata = rd;
        @(posedge clk); #1;
        m32.mem_ack = 1'b0;
        m32.mem_rdata = 32'h0;
        check({tag, "_resp"}, 64'(r32.resp_valid), 64'd1);
        check({tag, "_mreq_done"}, 64'(m32.mem_req), 64'd0);
        @(posedge clk); #1;
        check({tag, "_resp_once"}, 64'(r32.resp_valid), 64'd0);
    endtask

    task automatic op64(input string tag, input logic st,
                        input logic [2:0] t, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] rd,
                        input logic [63:0] x_addr, input logic [7:0] x_be,
                        input logic [63:0] x_wd, input logic [63:0] x_ld);
        @(posedge clk); #1;
        r64.req_valid = 1'b1;
        r64.is_store = st;
        r64.trunc = t;
        r64.addr = a;
        r64.store_data = d;
        q64.push_back('{tag: tag, mis: 1'b0, ld: x_ld});
        @(posedge clk); #1;
        r64.req_valid = 1'b0;
        check({tag, "_mreq"}, 64'(m64.mem_req), 64'd1);
        check({tag, "_addr"}, m64.mem_addr, x_addr);
        check({tag, "_be"}, 64'(m64.mem_be), 64'(x_be));
        if (st)
            check({tag, "_wdata"}, m64.mem_wdata & be_mask(x_be),
                  x_wd & be_mask(x_be));
        m64.mem_ack = 1'b1;
        m64.mem_rdata = rd;
        @(posedge clk); #1;
        m64.mem_ack = 1'b0;
        check({tag, "_resp"}, 64'(r64.resp_valid), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        r32.req_valid = 1'b0; r32.is_store = 1'b0; r32.trunc = 3'd0;
        r32.addr = '0; r32.store_data = '0;
        m32.mem_ack = 1'b0; m32.mem_rdata = '0;
        r64.req_valid = 1'b0; r64.is_store = 1'b0; r64.trunc = 3'd0;
        r64.addr = '0; r64.store_data = '0;
        m64.mem_ack = 1'b0; m64.mem_rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        reset_check32("rst");
        check("rst64_req", 64'(m64.mem_req), 64'd0);

        op32("lb", 1'b0, 3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 0,
             32'h1000, 4'hF, 32'h0, 32'hFFFF_FF80);
        op32("lbu", 1'b0, 3'd3, 32'h1003, 32'h0, 32'h80FF_1234, 0,
             32'h1000, 4'hF, 32'h0, 32'h0000_0080);
        op32("sh", 1'b1, 3'd1, 32'h2002, 32'hDEAD_BEEF, 32'h5555_5555, 0,
             32'h2000, 4'hC, 32'hBEEF_0000, 32'h0000_0080);

        // misaligned word load: response next cycle, no bus activity
        @(posedge clk); #1;
        r32.req_valid = 1'b1; r32.is_store = 1'b0;
        r32.trunc = 3'd2; r32.addr = 32'h3001;
        q32.push_back('{tag: "lw_mis", mis: 1'b1, ld: 64'h0});
        @(posedge clk); #1;
        r32.req_valid = 1'b0;
        check("lw_mis_resp", 64'(r32.resp_valid), 64'd1);
        check("lw_mis_flag", 64'(r32.misaligned), 64'd1);
        check("lw_mis_noreq", 64'(m32.mem_req), 64'd0);
        @(posedge clk); #1;
        check("lw_mis_noreq2", 64'(m32.mem_req), 64'd0);
        check("lw_mis_once", 64'(r32.resp_valid), 64'd0);

        op32("sb", 1'b1, 3'd3, 32'h1001, 32'h0000_00AA, 32'h0, 0,
             32'h1000, 4'h2, 32'h0000_AA00, 32'h0);
        op32("lh_wait", 1'b0, 3'd0 + 3'd1, 32'h1002, 32'h0, 32'h80FF_1234, 4,
             32'h1000, 4'hF, 32'h0, 32'hFFFF_80FF);
        op32("lw", 1'b0, 3'd2, 32'h1004, 32'h0, 32'h1234_5678, 1,
             32'h1004, 4'hF, 32'h0, 32'h1234_5678);

        // reset in the second ACCESS cycle, then a late acknowledge
        @(posedge clk); #1;
        r32.req_valid = 1'b1; r32.is_store = 1'b0;
        r32.trunc = 3'd2; r32.addr = 32'h5000;
        @(posedge clk); #1;
        r32.req_valid = 1'b0;
        check("rmid_acc1", 64'(m32.mem_req), 64'd1);
        @(posedge clk); #1;
        check("rmid_acc2", 64'(m32.mem_req), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        reset_check32("rmid");
        m32.mem_ack = 1'b1;
        m32.mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        m32.mem_ack = 1'b0;
        check("rmid_late_resp", 64'(r32.resp_valid), 64'd0);
        check("rmid_late_req", 64'(m32.mem_req), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rmid_quiet", 64'(r32.resp_valid), 64'd0);
        end

        op64("lwu64", 1'b0, 3'd5, 64'h4004, 64'h0,
             64'h8765_4321_0000_0000, 64'h4000, 8'hFF, 64'h0,
             64'h0000_0000_8765_4321);
        op64("lw64", 1'b0, 3'd2, 64'h4004, 64'h0,
             64'h8765_4321_0000_0000, 64'h4000, 8'hFF, 64'h0,
             64'hFFFF_FFFF_8765_4321);
        op64("ld64", 1'b0, 3'd6, 64'h4008, 64'h0,
             64'h0123_4567_89AB_CDEF, 64'h4008, 8'hFF, 64'h0,
             64'h0123_4567_89AB_CDEF);
        op64("sw64", 1'b1, 3'd2, 64'h4004, 64'h1122_3344, 64'h0,
             64'h4000, 8'hF0, 64'h1122_3344_0000_0000,
             64'h0123_4567_89AB_CDEF);

        @(posedge clk); #1;
        r64.req_valid = 1'b1; r64.is_store = 1'b0;
        r64.trunc = 3'd6; r64.addr = 64'h4004;
        q64.push_back('{tag: "ld64_mis", mis: 1'b1, ld: 64'h0});
        @(posedge clk); #1;
        r64.req_valid = 1'b0;
        check("ld64_mis_noreq", 64'(m64.mem_req), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        check("sb32_drained", 64'(q32.size()), 64'd0);
        check("sb64_drained", 64'(q64.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
